// File: rtl/mem_request_port.sv
// mem_request_port: per-node initiator for the shared SRAM arbiter.
// Buffers up to two CPU load/store commands, presents them one at a time as a
// held request level to the arbiter, waits for this node's grant (or gives up
// after TIMEOUT_CYCLES), and returns a one-cycle response in command order.
// Every request is followed by one all-low cycle so the arbiter always sees a
// fresh rising edge on the next request.
module mem_request_port #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DEPTH          = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        readRequest,
  output logic        writeRequest,
  output logic [15:0] ADDR,
  output logic [15:0] DATA,
  input  logic        requestDone,
  input  logic [15:0] DataToCPUs
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  state_t           state;
  state_t           next_state;

  // Two-entry command buffer; pointers are one bit wide because the depth is
  // fixed at two.
  cmd_t             fifo_mem [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;

  logic [CNT_W-1:0] wait_cnt;

  cmd_t             head;
  logic             push;
  logic             grant;
  logic             timeout;
  logic             pop;

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    next_state = state;
    head       = fifo_mem[rd_ptr];
    push       = cmd_valid && cmd_ready;
    grant      = (state == REQ) && requestDone;
    timeout    = (state == REQ) && !requestDone && (wait_cnt == LAST_WAIT);
    pop        = grant || timeout;
    count_next = count;

    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase

    unique case (state)
      IDLE: if (count != 2'd0) next_state = REQ;
      REQ:  if (pop) next_state = GAP;
      GAP:  next_state = (count != 2'd0) ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Buffer storage write; payload only, no reset needed.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately not reset: it is only read
    // while count > 0, so stale contents are never visible.
    if (push) fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  // Buffer pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count     <= count_next;
      cmd_ready <= (count_next != 2'd2);
    end
  end

  // Wait counter: zero outside REQ, counts REQ cycles spent without a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wait_cnt <= '0;
    else if ((state == REQ) && !pop) wait_cnt <= wait_cnt + CNT_W'(1);
    else                            wait_cnt <= '0;
  end

  // Arbiter-facing request level, address and data, loaded for the state
  // being entered so they are valid for the whole REQ cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readRequest  <= 1'b0;
      writeRequest <= 1'b0;
      ADDR         <= '0;
      DATA         <= '0;
    end else if (next_state == REQ) begin
      readRequest  <= ~head.write;
      writeRequest <= head.write;
      ADDR         <= head.addr;
      DATA         <= head.write ? head.wdata : 16'h0000;
    end else begin
      readRequest  <= 1'b0;
      writeRequest <= 1'b0;
      ADDR         <= '0;
      DATA         <= '0;
    end
  end

  // One-cycle response for each completed or abandoned command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= pop;
      rsp_write <= pop && head.write;
      rsp_error <= timeout;
      rsp_rdata <= (grant && !head.write) ? DataToCPUs : 16'h0000;
    end
  end

endmodule

// File: tb/tb_mem_request_port.sv
// Directed bench for mem_request_port with TIMEOUT_CYCLES = 8. The arbiter is
// played by the stimulus itself: grants and read data are driven at fixed
// points and every expected value is written out by hand.
module tb_mem_request_port;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        readRequest;
  logic        writeRequest;
  logic [15:0] ADDR;
  logic [15:0] DATA;
  logic        requestDone;
  logic [15:0] DataToCPUs;

  int checks   = 0;
  int failures = 0;

  mem_request_port #(.TIMEOUT_CYCLES(8), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .readRequest  (readRequest),
    .writeRequest (writeRequest),
    .ADDR         (ADDR),
    .DATA         (DATA),
    .requestDone  (requestDone),
    .DataToCPUs   (DataToCPUs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d);
    check({tag, ".readRequest"},  {31'd0, readRequest},  {31'd0, rd});
    check({tag, ".writeRequest"}, {31'd0, writeRequest}, {31'd0, wr});
    check({tag, ".ADDR"},         {16'd0, ADDR},         {16'd0, a});
    check({tag, ".DATA"},         {16'd0, DATA},         {16'd0, d});
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic w,
                           input logic [15:0] rd, input logic e);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    check({tag, ".rsp_write"}, {31'd0, rsp_write}, {31'd0, w});
    check({tag, ".rsp_rdata"}, {16'd0, rsp_rdata}, {16'd0, rd});
    check({tag, ".rsp_error"}, {31'd0, rsp_error}, {31'd0, e});
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [15:0] a,
                           input logic [15:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    requestDone = 1'b0;
    DataToCPUs  = '0;

    // Reset held with random inputs: every output stays at its reset value.
    for (int i = 0; i < 4; i++) begin
      cmd_valid   = 1'($urandom);
      cmd_write   = 1'($urandom);
      cmd_addr    = 16'($urandom);
      cmd_wdata   = 16'($urandom);
      requestDone = 1'($urandom);
      DataToCPUs  = 16'($urandom);
      tick();
      check("reset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_req("reset", 1'b0, 1'b0, 16'h0000, 16'h0000);
      check_rsp("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    end
    drive_cmd(1'b0, 1'b0, 16'h0000, 16'h0000);
    requestDone = 1'b0;
    DataToCPUs  = '0;
    reset       = 1'b1;
    tick();

    // Spurious grant while idle: no response, no request.
    requestDone = 1'b1;
    DataToCPUs  = 16'h5A5A;
    tick();
    tick();
    check_rsp("spurious", 1'b0, 1'b0, 16'h0000, 1'b0);
    check_req("spurious", 1'b0, 1'b0, 16'h0000, 16'h0000);
    requestDone = 1'b0;
    DataToCPUs  = '0;
    tick();

    // Single load of 0x0040, granted in the third request cycle with 0xBEEF.
    drive_cmd(1'b1, 1'b0, 16'h0040, 16'hFFFF);
    tick();                                    // E0: accepted
    drive_cmd(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("load.ready_after_accept", {31'd0, cmd_ready}, 32'd1);
    check_req("load.E0", 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();                                    // E1: request rises
    check_req("load.rise", 1'b1, 1'b0, 16'h0040, 16'h0000);
    tick();
    check_req("load.hold2", 1'b1, 1'b0, 16'h0040, 16'h0000);
    tick();
    check_req("load.hold3", 1'b1, 1'b0, 16'h0040, 16'h0000);
    check("load.no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    requestDone = 1'b1;
    DataToCPUs  = 16'hBEEF;
    tick();                                    // Eg
    requestDone = 1'b0;
    DataToCPUs  = 16'h0000;
    check_rsp("load.rsp", 1'b1, 1'b0, 16'hBEEF, 1'b0);
    check_req("load.gap", 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("load.single_pulse", {31'd0, rsp_valid}, 32'd0);
    check_req("load.idle", 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Back-to-back store 0x0010/0x1234 and load 0x0011; third command stalls.
    drive_cmd(1'b1, 1'b1, 16'h0010, 16'h1234);
    tick();
    drive_cmd(1'b1, 1'b0, 16'h0011, 16'hAAAA);
    tick();
    check_req("b2b.store", 1'b0, 1'b1, 16'h0010, 16'h1234);
    check("b2b.full", {31'd0, cmd_ready}, 32'd0);
    drive_cmd(1'b1, 1'b1, 16'h0020, 16'h5555);
    tick();
    check("b2b.stall", {31'd0, cmd_ready}, 32'd0);
    check_req("b2b.store_hold", 1'b0, 1'b1, 16'h0010, 16'h1234);
    requestDone = 1'b1;
    tick();                                    // store granted, third still waits
    requestDone = 1'b0;
    check_rsp("b2b.store_rsp", 1'b1, 1'b1, 16'h0000, 1'b0);
    check_req("b2b.gap", 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("b2b.ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    tick();                                    // third accepted, load request rises
    drive_cmd(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_req("b2b.load", 1'b1, 1'b0, 16'h0011, 16'h0000);
    check("b2b.rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    check("b2b.full_again", {31'd0, cmd_ready}, 32'd0);
    requestDone = 1'b1;
    DataToCPUs  = 16'h4321;
    tick();
    requestDone = 1'b0;
    DataToCPUs  = 16'h0000;
    check_rsp("b2b.load_rsp", 1'b1, 1'b0, 16'h4321, 1'b0);
    tick();

    // Timeout: the queued store 0x0020 is never granted; load 0x0030 queues.
    check_req("to.rise", 1'b0, 1'b1, 16'h0020, 16'h5555);
    drive_cmd(1'b1, 1'b0, 16'h0030, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to.held_c%0d", i), {31'd0, writeRequest}, 32'd1);
      check($sformatf("to.no_rsp_c%0d", i), {31'd0, rsp_valid}, 32'd0);
      tick();
      drive_cmd(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    check_rsp("to.rsp", 1'b1, 1'b1, 16'h0000, 1'b1);
    check_req("to.dropped", 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Grant exactly on the timeout edge: normal response wins.
    check_req("tog.rise", 1'b1, 1'b0, 16'h0030, 16'h0000);
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("tog.held_c%0d", i), {31'd0, readRequest}, 32'd1);
      tick();
    end
    check("tog.held_c8", {31'd0, readRequest}, 32'd1);
    requestDone = 1'b1;
    DataToCPUs  = 16'h00AA;
    tick();
    requestDone = 1'b0;
    DataToCPUs  = 16'h0000;
    check_rsp("tog.rsp", 1'b1, 1'b0, 16'h00AA, 1'b0);
    tick();
    check_req("tog.idle", 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset asserted mid-request with two commands queued.
    drive_cmd(1'b1, 1'b0, 16'h0050, 16'h0000);
    tick();
    drive_cmd(1'b1, 1'b1, 16'h0060, 16'h7777);
    tick();
    drive_cmd(1'b0, 1'b0, 16'h0000, 16'h0000);
    check_req("rst.req_up", 1'b1, 1'b0, 16'h0050, 16'h0000);
    check("rst.full", {31'd0, cmd_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_req("rst.async", 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("rst.async_ready", {31'd0, cmd_ready}, 32'd1);
    check_rsp("rst.async", 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    reset = 1'b1;
    requestDone = 1'b1;
    DataToCPUs  = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst.after_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
      check($sformatf("rst.after_req_%0d", i), {30'd0, readRequest, writeRequest}, 32'd0);
      check($sformatf("rst.after_ready_%0d", i), {31'd0, cmd_ready}, 32'd1);
    end
    requestDone = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_request_port.md
# mem_request_port

Per-node initiator for the shared SRAM arbiter. Accepts load/store commands from one CPU core, buffers up to two, and drives that node's `readRequest`/`writeRequest` bit, address and write data. It then waits for the arbiter's `requestDone` grant, captures read data from the shared `DataToCPUs` bus, and returns a one-cycle response. Five instances sit between the five CPU cores and the arbiter, one per request bit.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles a request stays asserted without a grant before it is abandoned; must be at least 2.
- `DEPTH`, 2: command buffer entries; fixed at 2.

- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: CPU presents a command.
- `cmd_ready` out 1: buffer not full; a command is accepted on an edge where `cmd_valid` and `cmd_ready` are both high.
- `cmd_write` in 1: 1 = store, 0 = load.
- `cmd_addr` in 16: word address.
- `cmd_wdata` in 16: store data.
- `rsp_valid` out 1: one-cycle response pulse, issued once per accepted command, in order.
- `rsp_write` out 1: type of the completed command.
- `rsp_rdata` out 16: load data; 0 for stores and errors.
- `rsp_error` out 1: command abandoned on timeout.
- `readRequest` out 1: read request to the arbiter.
- `writeRequest` out 1: write request to the arbiter.
- `ADDR` out 16: address to the arbiter.
- `DATA` out 16: write data to the arbiter.
- `requestDone` in 1: this node's grant bit from the arbiter.
- `DataToCPUs` in 16: shared SRAM read bus.

## Operation
- Command buffer: 2-entry FIFO holding {write, addr, wdata} per entry.
  - `cmd_ready` = count < 2.
  - Push and pop on the same edge are legal; count is unchanged.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - All request outputs low.
  - Transitions to REQ on the next edge when count > 0.
- REQ:
  - Drives from the FIFO head: `writeRequest` = head.write, `readRequest` = ~head.write, `ADDR` = head.addr, `DATA` = head.wdata (0 for loads).
  - The request is a level held until the grant. The arbiter edge-detects requests and checks `writeRequest` while serving, so the level must not drop before the grant.
- Grant: `requestDone` sampled high at an edge while in REQ.
  - Pop the head.
  - Register `rsp_valid`=1, `rsp_write`=head.write, `rsp_error`=0.
  - Register `rsp_rdata` = `DataToCPUs` for loads, 0 for stores.
  - Go to GAP.
- Timeout: a wait counter of width clog2(`TIMEOUT_CYCLES`+1) is cleared on entering REQ and increments each REQ cycle without a grant.
  - At the edge where the counter equals `TIMEOUT_CYCLES`-1 and `requestDone` is low: pop the head, register `rsp_valid`=1 and `rsp_error`=1, go to GAP.
  - A grant on that same edge wins: normal response, no error.
- GAP:
  - Request outputs, `ADDR` and `DATA` all 0 for exactly one cycle, which guarantees the arbiter sees a fresh rising edge.
  - Next edge goes to REQ if count > 0, else IDLE.
- `requestDone` high in IDLE or GAP is ignored; no response, no state change.
- `readRequest` and `writeRequest` are never high simultaneously.
- `ADDR`/`DATA` are 0 outside REQ.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0, `rsp_error`=0, `readRequest`=0, `writeRequest`=0, `ADDR`=0, `DATA`=0. State = IDLE, FIFO empty, counter = 0.
- Accept at edge E0 (IDLE, buffer empty): request outputs high after E1.
- Grant sampled at edge Eg: `rsp_valid` high for the cycle after Eg, and the request is low in that same cycle.
- If another entry is queued, the next request rises after Eg+1. Minimum spacing is one low cycle between requests, so peak throughput is one command per 2 cycles plus arbiter latency.
- With no grant, a command is abandoned after exactly `TIMEOUT_CYCLES` REQ cycles.
- `cmd_ready` reflects the count after the current edge. A full buffer with a pop on the same edge shows `cmd_ready`=1 the following cycle, not combinationally.
- Reset asserted mid-REQ:
  - All outputs return to their reset values immediately (asynchronously).
  - Buffered commands are discarded with no response.

## Test plan
- Reset: hold `reset`=0, drive random inputs -> every output equals its reset value; `cmd_ready`=1.
- Single load: accept addr 0x0040. Arbiter model grants 3 cycles after the rise with `DataToCPUs`=0xBEEF -> `readRequest`=1 and `ADDR`=0x0040 until the grant; `rsp_valid` pulses once with `rsp_rdata`=0xBEEF, `rsp_error`=0, `rsp_write`=0.
- Back-to-back: store (0x0010, 0x1234) then load 0x0011 in consecutive cycles; third command stalls -> `cmd_ready`=0 with 2 queued; `writeRequest` with `DATA`=0x1234, then exactly one all-low cycle, then `readRequest` with `ADDR`=0x0011; responses in order.
- Timeout: `TIMEOUT_CYCLES`=8, never grant -> request high for exactly 8 cycles, then `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0; next queued command proceeds.
- Grant on the timeout edge: grant exactly at cycle 8 with `DataToCPUs`=0x00AA -> `rsp_error`=0, `rsp_rdata`=0x00AA.
- Spurious grant and mid-op reset: `requestDone`=1 while IDLE -> no `rsp_valid`. Assert `reset` during REQ with 2 queued -> outputs clear immediately; after release the buffer is empty, `cmd_ready`=1, and no response is emitted.
